bus_stall_ctrl: RTL and testbench
=================================

Name: bus_stall_ctrl

Overview:
- Single shared memory-bus port arbitrated between instruction fetch (IF) and the data-memory stage (MEM).
- Sequences each access as request -> bus handshake -> buffered result, and owns the pipeline stall vector stall[5:0] consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).
- stall[0]=pc, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = Stop.
- A stage register inserts a bubble when its own stage is stopped and the next stage is not.

Parameters:
- TIMEOUT_CYCLES, 16, bus cycles to wait for bus_ack before aborting an access.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF stage needs an instruction word
- if_addr  in  32  fetch address
- if_flush  in  1  discard any pending/buffered fetch (branch redirect)
- if_rdata  out  32  buffered instruction word
- mem_req  in  1  MEM stage needs a load/store
- mem_we  in  1  1 = store
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_sel  in  4  byte enables
- mem_rdata  out  32  buffered load data
- stallreq_from_id  in  1  ID hazard stall request
- stallreq_from_ex  in  1  EX multi-cycle stall request
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_sel  out  4  bus byte enables
- bus_ack  in  1  bus completes the cycle this clock
- bus_rdata  in  32  bus read data, valid with bus_ack
- bus_err  out  1  one-cycle pulse on timeout abort
- stall  out  6  pipeline stall vector

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all bus_* outputs 0; if_rdata=mem_rdata=ZeroWord.
  - Both buffer-valid flags 0; discard flag 0; counter 0; bus_err 0.
  - stall is combinational and therefore 000000 while no requests are present.
- Buffers: if_vld and mem_vld.
  - if_pend = if_req & ~if_vld; mem_pend = mem_req & ~mem_vld.
- stall (combinational) = bitwise OR of:
  - 011111 if mem_pend
  - 001111 if stallreq_from_ex
  - 000111 if stallreq_from_id or if_pend
- Buffer consumption at the clock edge:
  - if_vld clears where stall[1]=0, or on if_flush.
  - mem_vld clears where stall[4]=0.
- FSM states IDLE, IF_ACC, MEM_ACC:
  - IDLE: if mem_pend -> MEM_ACC, latching mem_we/addr/wdata/sel into the bus registers. Else if if_pend & ~if_flush -> IF_ACC, latching if_addr with we=0 and sel=1111. Else stay. MEM has priority on simultaneous requests.
  - X_ACC: bus_req=1, counter increments.
    - On bus_ack: the X buffer captures bus_rdata (stores capture ZeroWord), X_vld<=1, state -> IDLE, bus_req drops next cycle.
    - On counter = TIMEOUT_CYCLES-1 without ack: bus_err pulses for one cycle, the buffer is loaded with ZeroWord, X_vld<=1, state -> IDLE.
- Latency: request seen in IDLE at cycle 0; bus_req in cycle 1; ack in cycle k (k>=1) -> vld=1 and stall released in cycle k+1. Minimum two stall cycles per access.
- Bus outputs are stable while bus_req=1; the bus transaction is never abandoned before ack or timeout.
- if_flush:
  - During IF_ACC: sets discard, and the access still completes.
  - On completion with discard set: data is dropped, if_vld stays 0, discard clears.
  - if_flush does not affect MEM accesses.
- if_req arriving during MEM_ACC: it is served after return to IDLE.
- mem_req rising during IF_ACC: it waits, and stall=011111 from that cycle.
- rst asserted mid-access: immediate abort, bus_req=0 asynchronously.

Decomposition:
- Shared defines header gains:
  - state encodings (STATE_IDLE/IF_ACC/MEM_ACC)
  - stall vectors (StallIf 000111, StallEx 001111, StallMem 011111)
  - reuse of existing Stop/NoStop, ZeroWord and RstEnable-style constants
- One natural sub-module: bus_timeout_cnt (counter with clear/enable/expire), instanced once.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000040, ack in the 2nd ACC cycle with rdata=0x24010005 -> bus_addr=0x40, stall=000111 for 3 cycles, then if_rdata=0x24010005 and stall=000000.
- Simultaneous if_req and mem load to 0x100 -> the MEM access is issued first with stall=011111. After its ack, the IF access is issued with stall=000111, and mem_rdata is held until stall[4]=0.
- Store: mem_we=1, sel=0011, wdata=0xDEADBEEF -> bus_we=1 and bus_wdata/sel match. After ack, mem_rdata=0 and stall[4] releases.
- No ack for 16 cycles -> bus_err high exactly one cycle, buffer=0, stall released, FSM in IDLE.
- if_flush during IF_ACC, ack with 0x1234 -> if_vld stays 0, the new if_addr is fetched next, and 0x1234 never reaches if_rdata.
- stallreq_from_ex with no memory requests -> stall=001111, bus_req=0. Reset asserted mid-MEM_ACC -> bus_req and stall drop to 0 without waiting for clk.

Source files
------------

// File: rtl/bus_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_stall_ctrl_pkg
//  Description : Shared constants for the bus/stall controller. This covers
//                the FSM state encodings, the pipeline stall vectors, the
//                stop/no-stop flags, the zero word and the reset level.
//                It also provides a helper that merges the stall requests.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_stall_ctrl_pkg;

    // FSM state encodings
    localparam logic [1:0] c_state_idle    = 2'd0;
    localparam logic [1:0] c_state_if_acc  = 2'd1;
    localparam logic [1:0] c_state_mem_acc = 2'd2;

    // Stall vectors: bit 0 = pc, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB
    localparam logic [5:0] c_stall_none = 6'b000000;
    localparam logic [5:0] c_stall_if   = 6'b000111;
    localparam logic [5:0] c_stall_ex   = 6'b001111;
    localparam logic [5:0] c_stall_mem  = 6'b011111;

    localparam logic        c_stop       = 1'b1;
    localparam logic        c_no_stop    = 1'b0;
    localparam logic [31:0] c_zero_word  = 32'h0000_0000;
    localparam logic        c_rst_enable = 1'b0;   // reset is active-low

    // A deeper stage stopping also stops every earlier stage, so the
    // requests simply OR together.
    function automatic logic [5:0] stall_merge(input logic mem_pend,
                                               input logic ex_req,
                                               input logic id_or_if);
        logic [5:0] v;
        v = c_stall_none;
        if (mem_pend) v = v | c_stall_mem;
        if (ex_req)   v = v | c_stall_ex;
        if (id_or_if) v = v | c_stall_if;
        return v;
    endfunction

endpackage : bus_stall_ctrl_pkg
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timeout_cnt
//  Description : Counts the bus cycles of an access. The expire output is
//                asserted in the final permitted cycle without an
//                acknowledge.
//  Ports       : clk, rst (async, active-low)
//                clr     - return count to zero (takes priority over en)
//                en      - count this cycle
//                expire  - en and count == TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt
    import bus_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_rst_enable) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = en && (r_cnt == c_last);

endmodule : bus_timeout_cnt
`default_nettype wire

// File: rtl/bus_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_stall_ctrl
//  Description : Arbitrates one memory-bus port between instruction fetch
//                and the MEM stage. MEM wins when both request. Each access
//                is buffered, and the controller drives the pipeline stall
//                vector.
//  Ports       : clk, rst (async, active-low)
//                if_req/if_addr/if_flush -> if_rdata     fetch side
//                mem_req/we/addr/wdata/sel -> mem_rdata  data side
//                stallreq_from_id/ex                     hazard requests
//                bus_req/we/addr/wdata/sel, bus_ack/rdata, bus_err
//                stall[5:0]                              1 = stop stage
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_stall_ctrl
    import bus_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [5:0]  stall
);

    logic [1:0]  r_state;
    logic        r_if_vld;
    logic        r_mem_vld;
    logic        r_discard;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_sel;
    logic        r_bus_err;

    logic        w_if_pend;
    logic        w_mem_pend;
    logic        w_in_acc;
    logic        w_expire;
    logic        w_done;
    logic [5:0]  w_stall;

    assign w_if_pend  = if_req  & ~r_if_vld;
    assign w_mem_pend = mem_req & ~r_mem_vld;
    assign w_in_acc   = (r_state != c_state_idle);
    assign w_done     = bus_ack | w_expire;

    assign w_stall = stall_merge(w_mem_pend, stallreq_from_ex,
                                 stallreq_from_id | w_if_pend);

    // Gating with reset lets the stall vector drop together with bus_req
    // the moment reset is asserted. It does not wait for the buffers to be
    // cleared by a clock edge.
    assign stall = (rst == c_rst_enable) ? c_stall_none : w_stall;

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (~w_in_acc),
        .en     (w_in_acc),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_rst_enable) begin
            r_state     <= c_state_idle;
            r_if_vld    <= 1'b0;
            r_mem_vld   <= 1'b0;
            r_discard   <= 1'b0;
            r_if_rdata  <= c_zero_word;
            r_mem_rdata <= c_zero_word;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= c_zero_word;
            r_bus_wdata <= c_zero_word;
            r_bus_sel   <= 4'b0000;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;

            // A buffered word is consumed when its stage advances. Any
            // capture below happens later in this block, so a capture in
            // the same cycle overrides the consumption.
            if ((w_stall[1] == c_no_stop) || if_flush) r_if_vld <= 1'b0;
            if (w_stall[4] == c_no_stop)               r_mem_vld <= 1'b0;

            case (r_state)
                c_state_idle: begin
                    if (w_mem_pend) begin
                        r_state     <= c_state_mem_acc;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                        r_bus_sel   <= mem_sel;
                    end else if (w_if_pend && !if_flush) begin
                        r_state     <= c_state_if_acc;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= c_zero_word;
                        r_bus_sel   <= 4'b1111;
                    end
                end

                c_state_if_acc: begin
                    // A redirect cannot cancel a bus cycle that is already
                    // running. The access completes and its result is
                    // discarded.
                    if (if_flush) r_discard <= 1'b1;
                    if (w_done) begin
                        r_state   <= c_state_idle;
                        r_bus_req <= 1'b0;
                        r_bus_err <= ~bus_ack;
                        if (r_discard || if_flush) begin
                            r_discard <= 1'b0;
                        end else begin
                            r_if_vld   <= 1'b1;
                            r_if_rdata <= bus_ack ? bus_rdata : c_zero_word;
                        end
                    end
                end

                c_state_mem_acc: begin
                    if (w_done) begin
                        r_state     <= c_state_idle;
                        r_bus_req   <= 1'b0;
                        r_bus_err   <= ~bus_ack;
                        r_mem_vld   <= 1'b1;
                        r_mem_rdata <= (bus_ack && !r_bus_we) ? bus_rdata
                                                              : c_zero_word;
                    end
                end

                default: begin
                    r_state   <= c_state_idle;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;
    assign bus_err   = r_bus_err;

endmodule : bus_stall_ctrl
`default_nettype wire

// File: tb/tb_bus_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_stall_ctrl
//  Description : Self-checking bench for bus_stall_ctrl. Each expected
//                access is queued when the request is driven. The queue
//                entry is popped and compared when the DUT raises bus_req.
//                A small bus responder supplies the ack, the timeout or the
//                flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_stall_ctrl;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic        stallreq_from_id, stallreq_from_ex, bus_ack;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        bus_req, bus_we, bus_err;
    logic [3:0]  bus_sel;
    logic [5:0]  stall;

    always #5 clk = ~clk;

    bus_stall_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_flush         (if_flush),
        .if_rdata         (if_rdata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_sel          (mem_sel),
        .mem_rdata        (mem_rdata),
        .stallreq_from_id (stallreq_from_id),
        .stallreq_from_ex (stallreq_from_ex),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_sel          (bus_sel),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata),
        .bus_err          (bus_err),
        .stall            (stall)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;       // what the bus responder returns
        logic [31:0] exp_buf;     // buffer contents after completion
        logic [5:0]  stall_acc;   // stall during the first access cycle
        logic [5:0]  stall_after; // stall in the cycle after completion
    } txn_t;

    txn_t sb[$];

    task automatic push_txn(input bit is_mem, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input logic [31:0] rdata,
                            input logic [31:0] exp_buf,
                            input logic [5:0] s_acc, input logic [5:0] s_after);
        txn_t t;
        t.is_mem = is_mem; t.we = we; t.addr = addr; t.wdata = wdata;
        t.sel = sel; t.rdata = rdata; t.exp_buf = exp_buf;
        t.stall_acc = s_acc; t.stall_after = s_after;
        sb.push_back(t);
    endtask

    // Responds to one bus access. ack_at is the access cycle (counted from 1)
    // that carries bus_ack; 0 means never acknowledge, which forces a
    // timeout. flush_at pulses if_flush together with a redirected if_addr.
    task automatic serve(input int ack_at, input int flush_at,
                         input logic [31:0] redirect);
        txn_t t;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus_req) seen = 1'b1;
        end
        if (!seen) begin
            check_val("bus_req_start", {31'b0, bus_req}, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check_val("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        t = sb.pop_front();
        check_val("bus_addr",  bus_addr,         t.addr);
        check_val("bus_we",    {31'b0, bus_we},  {31'b0, t.we});
        check_val("bus_sel",   {28'b0, bus_sel}, {28'b0, t.sel});
        if (t.we) check_val("bus_wdata", bus_wdata, t.wdata);
        check_val("stall_acc", {26'b0, stall},   {26'b0, t.stall_acc});

        if (ack_at == 0) begin
            for (int n = 2; n <= TIMEOUT_CYCLES; n++) @(negedge clk);
            check_val("to_bus_req_held", {31'b0, bus_req}, 32'd1);
            check_val("to_no_err_early", {31'b0, bus_err}, 32'd0);
            @(negedge clk);
            check_val("to_bus_err",      {31'b0, bus_err}, 32'd1);
            check_val("to_bus_req_drop", {31'b0, bus_req}, 32'd0);
        end else begin
            for (int n = 1; n <= ack_at; n++) begin
                if (n > 1) @(negedge clk);
                if_flush = (n == flush_at);
                if (n == flush_at) if_addr = redirect;
                if (n == ack_at) begin
                    check_val("bus_addr_stable", bus_addr, t.addr);
                    bus_ack   = 1'b1;
                    bus_rdata = t.rdata;
                end
            end
            @(negedge clk);
            bus_ack   = 1'b0;
            if_flush  = 1'b0;
            bus_rdata = 32'hBAD0_BAD0;
            check_val("bus_req_drop", {31'b0, bus_req}, 32'd0);
        end
        check_val(t.is_mem ? "mem_rdata" : "if_rdata",
                  t.is_mem ? mem_rdata : if_rdata, t.exp_buf);
        check_val("stall_after", {26'b0, stall}, {26'b0, t.stall_after});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b0;
        if_req = 0; if_flush = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;
        stallreq_from_id = 0; stallreq_from_ex = 0;
        bus_ack = 0; bus_rdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_bus_req",   {31'b0, bus_req}, 32'd0);
        check_val("rst_bus_err",   {31'b0, bus_err}, 32'd0);
        check_val("rst_bus_addr",  bus_addr,         32'd0);
        check_val("rst_stall",     {26'b0, stall},   32'd0);
        check_val("rst_if_rdata",  if_rdata,         32'd0);
        check_val("rst_mem_rdata", mem_rdata,        32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch only: ack in the second access cycle
        push_txn(0, 0, 32'h40, 32'h0, 4'hF, 32'h2401_0005, 32'h2401_0005,
                 6'b000111, 6'b000000);
        if_req = 1; if_addr = 32'h40;
        #1 check_val("fetch_stall_idle", {26'b0, stall}, 32'b000111);
        serve(2, 0, 32'h0);
        if_req = 0;
        @(negedge clk);
        check_val("fetch_idle_stall", {26'b0, stall}, 32'd0);
        check_val("fetch_hold",       if_rdata,       32'h2401_0005);

        // Simultaneous fetch and load: MEM goes first
        push_txn(1, 0, 32'h100, 32'h0, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D,
                 6'b011111, 6'b000111);
        push_txn(0, 0, 32'h44, 32'h0, 4'hF, 32'h1111_2222, 32'h1111_2222,
                 6'b000111, 6'b000000);
        mem_req = 1; mem_we = 0; mem_addr = 32'h100; mem_sel = 4'hF;
        if_req = 1; if_addr = 32'h44;
        serve(1, 0, 32'h0);
        mem_req = 0;
        serve(2, 0, 32'h0);
        if_req = 0;
        check_val("load_data_held", mem_rdata, 32'hCAFE_F00D);

        // Store: buffer reads back zero
        push_txn(1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 32'hFFFF_FFFF,
                 32'h0, 6'b011111, 6'b000000);
        mem_req = 1; mem_we = 1; mem_addr = 32'h200;
        mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
        serve(3, 0, 32'h0);
        mem_req = 0; mem_we = 0;

        // Timeout on a fetch
        push_txn(0, 0, 32'h80, 32'h0, 4'hF, 32'h0, 32'h0,
                 6'b000111, 6'b000000);
        if_req = 1; if_addr = 32'h80;
        serve(0, 0, 32'h0);
        if_req = 0;
        @(negedge clk);
        check_val("to_err_one_cycle", {31'b0, bus_err}, 32'd0);
        check_val("to_idle_bus_req",  {31'b0, bus_req}, 32'd0);
        check_val("to_idle_stall",    {26'b0, stall},   32'd0);

        // Flush during a fetch: 0x1234 dropped, redirect target fetched next
        push_txn(0, 0, 32'h300, 32'h0, 4'hF, 32'h0000_1234, 32'h0,
                 6'b000111, 6'b000111);
        push_txn(0, 0, 32'h400, 32'h0, 4'hF, 32'h5566_7788, 32'h5566_7788,
                 6'b000111, 6'b000000);
        if_req = 1; if_addr = 32'h300;
        serve(3, 1, 32'h400);
        serve(1, 0, 32'h0);
        if_req = 0;

        // EX and ID stall requests without memory traffic
        @(negedge clk);
        stallreq_from_ex = 1;
        #1 check_val("ex_stall", {26'b0, stall}, 32'b001111);
        repeat (3) @(negedge clk);
        check_val("ex_no_bus", {31'b0, bus_req}, 32'd0);
        stallreq_from_ex = 0; stallreq_from_id = 1;
        #1 check_val("id_stall", {26'b0, stall}, 32'b000111);
        @(negedge clk);
        check_val("id_no_bus", {31'b0, bus_req}, 32'd0);
        stallreq_from_id = 0;

        // Reset in the middle of a MEM access
        mem_req = 1; mem_we = 0; mem_addr = 32'h500; mem_sel = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_req) seen = 1'b1;
        end
        check_val("mr_bus_req_up", {31'b0, bus_req}, 32'd1);
        rst = 1'b0;
        #1;
        check_val("mr_bus_req_async", {31'b0, bus_req}, 32'd0);
        check_val("mr_stall_async",   {26'b0, stall},   32'd0);
        mem_req = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mr_bus_req_after", {31'b0, bus_req}, 32'd0);
        check_val("mr_if_rdata",      if_rdata,         32'd0);

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule : tb_bus_stall_ctrl
`default_nettype wire
